// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Definitions shared by the multiplier datapath blocks: lane count, lane-select
// width and the state encoding of the 1-to-8 lane collector.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int NLANES = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_e;

endpackage : mult_pkg

// File: rtl/demux1to8_collector_if.sv
// -----------------------------------------------------------------------------
// demux1to8_collector_if
// Beat-in / word-out bus of the lane collector.
//   Upstream : InValid, InReady, InSel, InData, InLast
//   Downstream: OutValid, OutReady, OutData, OutMask
//   Status   : OverwriteErr
// master = the surrounding logic (drives the beats and OutReady)
// slave  = the collector itself
// -----------------------------------------------------------------------------
interface demux1to8_collector_if #(
    parameter int WIDTH = 1
);
    import mult_pkg::*;

    logic                      InValid;
    logic                      InReady;
    logic [SEL_W-1:0]          InSel;
    logic [WIDTH-1:0]          InData;
    logic                      InLast;
    logic                      OutValid;
    logic                      OutReady;
    logic [NLANES*WIDTH-1:0]   OutData;
    logic [NLANES-1:0]         OutMask;
    logic                      OverwriteErr;

    modport master (
        output InValid, InSel, InData, InLast, OutReady,
        input  InReady, OutValid, OutData, OutMask, OverwriteErr
    );

    modport slave (
        input  InValid, InSel, InData, InLast, OutReady,
        output InReady, OutValid, OutData, OutMask, OverwriteErr
    );

endinterface : demux1to8_collector_if

// File: rtl/demux1to8_collector_decoder3to8.sv
// -----------------------------------------------------------------------------
// decoder3to8
// Combinational 3-to-8 one-hot decoder with enable: the structural inverse of
// the 8:1 lane select. Drives both the lane write enables and the mask update.
//   en_i     : accept strobe; all outputs low when 0
//   sel_i    : lane index 0..7
//   onehot_o : bit sel_i set when en_i = 1
// -----------------------------------------------------------------------------
module decoder3to8
    import mult_pkg::*;
(
    input  logic              en_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [NLANES-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule : decoder3to8

// File: rtl/demux1to8_collector.sv
// -----------------------------------------------------------------------------
// demux1to8_collector
// Gathers addressed lane writes (one beat per cycle) into eight WIDTH-bit lane
// registers and presents the assembled word with a valid/ready handshake once
// every lane is written or the frame is closed early with InLast.
//   Clk   : rising-edge clock
//   Reset : asynchronous, active-high
//   bus   : slave side of demux1to8_collector_if (beats in, word out,
//           OverwriteErr pulse one cycle after a repeated lane write)
// -----------------------------------------------------------------------------
module demux1to8_collector
    import mult_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    demux1to8_collector_if.slave  bus
);

    collect_state_e    state_q, state_d;
    logic [WIDTH-1:0]  lane_q [NLANES];
    logic [WIDTH-1:0]  lane_d [NLANES];
    logic [NLANES-1:0] mask_q, mask_d;
    logic              err_q, err_d;

    logic              accept;
    logic [NLANES-1:0] wr_en;

    // InReady depends on registered state only, so OutReady never reaches it
    // combinationally.
    assign accept = bus.InValid && (state_q == COLLECT);

    decoder3to8 u_decoder (
        .en_i     (accept),
        .sel_i    (bus.InSel),
        .onehot_o (wr_en)
    );

    // NOTE: every variable gets its default before the case statement, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        mask_d  = mask_q;
        err_d   = 1'b0;

        unique case (state_q)
            COLLECT: begin
                for (int k = 0; k < NLANES; k++) begin
                    if (wr_en[k]) begin
                        lane_d[k] = bus.InData;
                    end
                end
                mask_d = mask_q | wr_en;
                err_d  = |(mask_q & wr_en);
                // A beat that both fills the mask and carries InLast is one close.
                if (accept && ((&mask_d) || bus.InLast)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.OutReady) begin
                    for (int k = 0; k < NLANES; k++) begin
                        lane_d[k] = '0;
                    end
                    mask_d  = '0;
                    state_d = COLLECT;
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would make results depend on
    // statement order.
    // NOTE: the lane registers are reset along with the control state because
    // a discarded partial frame must never leak into the next word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NLANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
        end
    end

    assign bus.InReady      = (state_q == COLLECT);
    assign bus.OutValid     = (state_q == HOLD);
    assign bus.OutMask      = mask_q;
    assign bus.OverwriteErr = err_q;

    // Lane 0 sits at the LSBs; unwritten lanes are still zero from the clear.
    always_comb begin
        bus.OutData = '0;
        for (int k = 0; k < NLANES; k++) begin
            bus.OutData[k*WIDTH +: WIDTH] = lane_q[k];
        end
    end

endmodule : demux1to8_collector

// File: tb/tb_demux1to8_collector.sv
// -----------------------------------------------------------------------------
// tb_demux1to8_collector
// Directed bench for two collector instances (WIDTH=4 and WIDTH=1). A frame
// model (written lanes, mask, holding flag) predicts every output; a compare
// process checks both DUTs against it on each falling edge, and the directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_demux1to8_collector;

    logic Clk;
    logic Reset;

    demux1to8_collector_if #(.WIDTH(4)) bus4 ();
    demux1to8_collector_if #(.WIDTH(1)) bus1 ();

    demux1to8_collector #(.WIDTH(4)) u_dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4));
    demux1to8_collector #(.WIDTH(1)) u_dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- frame model (index 0 = WIDTH 4, index 1 = WIDTH 1) ----
    int       m_lane [2][8];
    bit [7:0] m_mask [2];
    bit       m_hold [2];
    bit       m_err  [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_mask[i] = '0;
            m_hold[i] = 1'b0;
            m_err[i]  = 1'b0;
            for (int k = 0; k < 8; k++) m_lane[i][k] = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit v, input int sel, input int data,
                              input bit last, input bit ordy);
        m_err[i] = 1'b0;
        if (!m_hold[i]) begin
            if (v) begin
                m_err[i]         = m_mask[i][sel];
                m_lane[i][sel]   = data;
                m_mask[i][sel]   = 1'b1;
                if (m_mask[i] == 8'hFF || last) m_hold[i] = 1'b1;
            end
        end else if (ordy) begin
            m_hold[i] = 1'b0;
            m_mask[i] = '0;
            for (int k = 0; k < 8; k++) m_lane[i][k] = 0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                model_clear();
            end else begin
                model_edge(0, bus4.InValid, int'(bus4.InSel), int'(bus4.InData),
                           bus4.InLast, bus4.OutReady);
                model_edge(1, bus1.InValid, int'(bus1.InSel), int'(bus1.InData),
                           bus1.InLast, bus1.OutReady);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [31:0] e4;
        logic [7:0]  e1;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                e4 = '0;
                e1 = '0;
                for (int k = 0; k < 8; k++) begin
                    e4 = e4 | (32'(m_lane[0][k] & 15) << (4 * k));
                    e1 = e1 | (8'(m_lane[1][k] & 1) << k);
                end
                check("w4_out_valid", 64'(bus4.OutValid),     64'(m_hold[0]));
                check("w4_in_ready",  64'(bus4.InReady),      64'(!m_hold[0]));
                check("w4_out_mask",  64'(bus4.OutMask),      64'(m_mask[0]));
                check("w4_ovw_err",   64'(bus4.OverwriteErr), 64'(m_err[0]));
                check("w4_out_data",  64'(bus4.OutData),      64'(e4));
                check("w1_out_valid", 64'(bus1.OutValid),     64'(m_hold[1]));
                check("w1_in_ready",  64'(bus1.InReady),      64'(!m_hold[1]));
                check("w1_out_mask",  64'(bus1.OutMask),      64'(m_mask[1]));
                check("w1_ovw_err",   64'(bus1.OverwriteErr), 64'(m_err[1]));
                check("w1_out_data",  64'(bus1.OutData),      64'(e1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat4(input int sel, input int data, input bit last);
        @(posedge Clk);
        #1;
        bus4.InValid = 1'b1;
        bus4.InSel   = 3'(sel);
        bus4.InData  = 4'(data);
        bus4.InLast  = last;
    endtask

    task automatic idle4();
        @(posedge Clk);
        #1;
        bus4.InValid = 1'b0;
        bus4.InLast  = 1'b0;
    endtask

    task automatic beat1(input int sel, input int data);
        @(posedge Clk);
        #1;
        bus1.InValid = 1'b1;
        bus1.InSel   = 3'(sel);
        bus1.InData  = 1'(data);
        bus1.InLast  = 1'b0;
    endtask

    task automatic idle1();
        @(posedge Clk);
        #1;
        bus1.InValid = 1'b0;
    endtask

    task automatic check_zero4(input string tag);
        check({tag, "_valid"}, 64'(bus4.OutValid), 64'(0));
        check({tag, "_mask"},  64'(bus4.OutMask),  64'(0));
        check({tag, "_data"},  64'(bus4.OutData),  64'(0));
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        bit [7:0] w1_bits;
        int       order[7];

        Reset = 1'b1;
        bus4.InValid = 1'b0; bus4.InSel = '0; bus4.InData = '0; bus4.InLast = 1'b0;
        bus4.OutReady = 1'b1;
        bus1.InValid = 1'b0; bus1.InSel = '0; bus1.InData = '0; bus1.InLast = 1'b0;
        bus1.OutReady = 1'b1;

        // Reset state
        #3;
        check_zero4("rst");
        check("rst_err", 64'(bus4.OverwriteErr), 64'(0));
        @(negedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_in_ready", 64'(bus4.InReady), 64'(1));

        // Sequential fill, OutReady held high
        for (int s = 0; s < 8; s++) beat4(s, s + 1, 1'b0);
        idle4();
        @(negedge Clk);
        check("fill_valid", 64'(bus4.OutValid), 64'(1));
        check("fill_data",  64'(bus4.OutData),  64'(32'h87654321));
        check("fill_mask",  64'(bus4.OutMask),  64'(8'hFF));
        check("fill_ready", 64'(bus4.InReady),  64'(0));
        @(negedge Clk);
        check("fill_ready_back", 64'(bus4.InReady),  64'(1));
        check("fill_valid_drop", 64'(bus4.OutValid), 64'(0));

        // Out-of-order beats with early close
        beat4(5, 4'hA, 1'b0);
        beat4(2, 4'hC, 1'b1);
        idle4();
        @(negedge Clk);
        check("early_valid", 64'(bus4.OutValid), 64'(1));
        check("early_data",  64'(bus4.OutData),  64'(32'h00A00C00));
        check("early_mask",  64'(bus4.OutMask),  64'(8'h24));
        @(negedge Clk);

        // Overwrite of lane 3
        beat4(3, 4'h5, 1'b0);
        beat4(3, 4'h9, 1'b0);
        idle4();
        @(negedge Clk);
        check("ovw_err",   64'(bus4.OverwriteErr), 64'(1));
        check("ovw_open",  64'(bus4.OutValid),     64'(0));
        check("ovw_mask",  64'(bus4.OutMask),      64'(8'h08));
        order = '{0, 1, 2, 4, 5, 6, 7};
        foreach (order[j]) beat4(order[j], order[j], 1'b0);
        idle4();
        @(negedge Clk);
        check("ovw_final_data", 64'(bus4.OutData), 64'(32'h76549210));
        check("ovw_final_mask", 64'(bus4.OutMask), 64'(8'hFF));
        @(negedge Clk);

        // Backpressure: HOLD for 5 cycles with a beat pending
        bus4.OutReady = 1'b0;
        for (int s = 0; s < 8; s++) beat4(s, s + 8, 1'b0);
        beat4(0, 4'h3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            check("bp_data",  64'(bus4.OutData),  64'(32'hFEDCBA98));
            check("bp_ready", 64'(bus4.InReady),  64'(0));
            check("bp_valid", 64'(bus4.OutValid), 64'(1));
        end
        @(posedge Clk);
        #1 bus4.OutReady = 1'b1;
        @(negedge Clk);
        check("bp_still_hold", 64'(bus4.OutValid), 64'(1));
        @(negedge Clk);
        check("bp_release_valid", 64'(bus4.OutValid), 64'(0));
        check("bp_release_ready", 64'(bus4.InReady),  64'(1));
        check("bp_release_mask",  64'(bus4.OutMask),  64'(0));
        idle4();
        @(negedge Clk);
        check("bp_next_mask", 64'(bus4.OutMask), 64'(8'h01));
        check("bp_next_data", 64'(bus4.OutData), 64'(32'h00000003));

        // Async reset mid-frame (lane 0 already holds 3, add three more)
        beat4(1, 4'h4, 1'b0);
        beat4(2, 4'h5, 1'b0);
        beat4(3, 4'h6, 1'b0);
        @(posedge Clk);
        #2;
        bus4.InValid = 1'b0;
        Reset = 1'b1;
        #1;
        check_zero4("rst_mid");
        @(negedge Clk);
        #1 Reset = 1'b0;

        // Async reset while holding
        bus4.OutReady = 1'b0;
        for (int s = 0; s < 8; s++) beat4(s, s + 1, 1'b0);
        idle4();
        @(negedge Clk);
        check("rst_hold_pre", 64'(bus4.OutValid), 64'(1));
        #2 Reset = 1'b1;
        #1;
        check_zero4("rst_hold");
        @(negedge Clk);
        #1 Reset = 1'b0;
        bus4.OutReady = 1'b1;

        // Fresh frame after reset, reverse order
        for (int s = 7; s >= 0; s--) beat4(s, 8 - s, 1'b0);
        idle4();
        @(negedge Clk);
        check("fresh_valid", 64'(bus4.OutValid), 64'(1));
        check("fresh_data",  64'(bus4.OutData),  64'(32'h12345678));
        check("fresh_mask",  64'(bus4.OutMask),  64'(8'hFF));
        @(negedge Clk);

        // WIDTH=1 instance
        w1_bits = 8'b01001101;
        for (int s = 0; s < 8; s++) beat1(s, int'(w1_bits[s]));
        idle1();
        @(negedge Clk);
        check("w1_valid", 64'(bus1.OutValid), 64'(1));
        check("w1_data",  64'(bus1.OutData),  64'(8'b01001101));
        check("w1_mask",  64'(bus1.OutMask),  64'(8'hFF));
        @(negedge Clk);
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_demux1to8_collector

// File: doc/demux1to8_collector.md
Name: demux1to8_collector

Overview:
- 1-to-8 demultiplexing capture block: the write-side counterpart of the 8:1 selection path in the multiplier datapath.
- Accepts addressed lane writes (data + 3-bit Sel), one per cycle, into eight WIDTH-bit lane registers.
- Presents the assembled 8-lane word downstream with a valid/ready handshake once all lanes are written or a frame is closed early with InLast.
- Used to gather partial-product / booth-digit lanes before parallel consumption.

Parameters:
WIDTH, 1, bits per lane; legal range 1..32.
NLANES, 8, lane count; fixed at 8, so Sel is 3 bits. Not overridable.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
InValid  input  1  upstream beat valid.
InReady  output  1  block can accept a beat.
InSel  input  3  destination lane index 0..7.
InData  input  WIDTH  lane data.
InLast  input  1  close the frame with this beat, even if lanes are missing.
OutValid  output  1  assembled word valid.
OutReady  input  1  downstream accepts the word.
OutData  output  8*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 at the LSBs.
OutMask  output  8  bit k set = lane k was written in this frame.
OverwriteErr  output  1  one-cycle pulse on a write to an already-written lane.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high; while Reset=1, all state clears immediately, independent of Clk.
- Reset values:
  - lane regs = 0, Mask = 0, state = COLLECT.
  - OutValid = 0, OutData = 0, OutMask = 0, OverwriteErr = 0.
  - InReady = 1 once Reset deasserts.
- States: COLLECT, HOLD.
- InReady = (state == COLLECT), registered-state-derived only. No combinational path from OutReady to InReady.
- Beat acceptance: a beat is accepted when InValid & InReady at a rising edge. On acceptance:
  - Lane[InSel] <= InData.
  - Mask[InSel] <= 1.
  - If Mask[InSel] was already 1: the data overwrites, Mask is unchanged, and OverwriteErr = 1 for the next cycle only.
- COLLECT -> HOLD: on the accepting edge where (Mask | onehot(InSel)) == 8'hFF, or InLast = 1.
  - OutValid rises in the cycle after the final beat (latency 1).
  - OutData and OutMask include that final beat.
- HOLD:
  - OutValid = 1.
  - OutData and OutMask are stable and must not change until the handshake completes.
  - InValid is ignored (InReady = 0).
- HOLD -> COLLECT: on the edge with OutValid & OutReady.
  - Lanes and Mask clear to 0; OutValid = 0 next cycle; InReady = 1 next cycle.
- Unwritten lanes of an early-closed (InLast) frame read as 0 in OutData, with the matching OutMask bits 0.
- Throughput: at best 8 beats + 1 handshake cycle per full frame. OutReady held high gives exactly one HOLD cycle.
- OutReady asserted while in COLLECT has no effect.
- InLast on a beat that also completes the mask: single transition, no double event.
- Reset asserted mid-frame or in HOLD: the partial frame is discarded and no OutValid pulse is produced.
- X on InSel while InValid=1 is a protocol violation; no recovery is defined.

Decomposition:
- Shared package `mult_pkg`:
  - state encoding COLLECT=1'b0, HOLD=1'b1
  - constant NLANES=8
  - constant SEL_W=3
- One natural sub-module, `decoder3to8` (combinational): InSel -> one-hot write enable, gated by the accept strobe. It is the structural inverse of the 8:1 select and is reused for the Mask update.

Test Plan:
- Sequential fill: WIDTH=4, sels 0..7 with data 0x1..0x8, OutReady=1. Required: OutValid one cycle after the 8th beat, OutData=32'h87654321, OutMask=8'hFF, InReady low for exactly 1 cycle.
- Out-of-order plus early close: sels 5,2 with data 0xA,0xC, InLast on the second beat. Required: OutData=32'h00A00C00, OutMask=8'h24.
- Overwrite: sel 3 data 0x5, then sel 3 data 0x9. Required: OverwriteErr pulses 1 cycle after the second beat, Mask[3]=1, lane3=0x9 in the final word, frame not closed early.
- Backpressure: complete a frame with OutReady=0 for 5 cycles while InValid=1 with new data. Required: OutData stable, InReady=0, no beat accepted. Raise OutReady: OutValid drops next cycle, and the next beat lands in a cleared frame.
- Async reset: assert Reset between clock edges after 4 beats, and again while in HOLD. Required: OutValid, OutMask and OutData go to 0 immediately. After release, a fresh 8-beat frame yields the correct word with no stale lanes.
- WIDTH=1 regression: 8 bits 1,0,1,1,0,0,1,0 to sels 0..7. Required: OutData=8'b01001101.
